uart_hex_sender: RTL and testbench

- Downstream of the monitor read/dump logic; consumes each `rdata_snd_start` / `rdata_snd` record.
- Converts the record to ASCII hex text and queues the characters.
- Drives the UART transmitter through a valid/ready byte handshake.
- Returns a one-cycle `flushing_wq` pulse once the last character of the record has been accepted, which advances the dump state machine.

---
 rtl/uart_mon_pkg.sv | 28 ++
 rtl/uart_char_fifo.sv | 67 ++++++
 rtl/uart_hex_sender.sv | 119 +++++++++++
 tb/tb_uart_hex_sender.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// Shared constants and helpers for the monitor UART dump path.
package uart_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } snd_state_e;

  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [4:0] LEN_LONG  = 5'd19;
  localparam logic [4:0] LEN_SHORT = 5'd10;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib, input logic upper);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + {4'h0, nib};
    end else begin
      ch = (upper ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
    end
    return ch;
  endfunction

endpackage

// File: rtl/uart_char_fifo.sv
// Character queue with a registered head; a pushed byte is visible on rdata the next cycle.
module uart_char_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       ready,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       full,
  output logic       empty_nxt
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            head_q, head_d;
  logic                  valid_q;
  logic                  pop, push_ok;

  assign full       = (cnt_q == CntW'(Depth));
  assign push_ok    = push & ~full;
  assign pop        = valid_q & ready;
  assign rd_ptr_nxt = rd_ptr_q + DEPTH_LOG2'(1);
  assign cnt_d      = cnt_q + CntW'(push_ok) - CntW'(pop);
  assign empty_nxt  = (cnt_q == '0) | ((cnt_q == CntW'(1)) & pop);
  assign rdata      = head_q;
  assign rvalid     = valid_q;

  // Head register tracks mem[rd_ptr]; bypass the write when the queue drains to it.
  always_comb begin
    head_d = head_q;
    if (pop && (cnt_q > CntW'(1))) begin
      head_d = mem_q[rd_ptr_nxt];
    end else if (push_ok && ((cnt_q == '0) || (pop && (cnt_q == CntW'(1))))) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)     rd_ptr_q <= rd_ptr_nxt;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/uart_hex_sender.sv
// Turns a monitor record into ASCII hex text and streams it to the UART TX.
module uart_hex_sender
  import uart_mon_pkg::*;
#(
  parameter int unsigned QDEPTH_LOG2 = 3,
  parameter bit          UPPER_HEX   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdata_snd_start,
  input  logic [63:0] rdata_snd,
  input  logic        pc_print_sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        flushing_wq,
  output logic        snd_busy,
  output logic        start_ovr
);

  snd_state_e  state_q, state_d;
  logic [63:0] data_q, data_d;
  logic        sel_q, sel_d;
  logic [4:0]  idx_q, idx_d;
  logic        ovr_q;
  logic [4:0]  last_idx;
  logic        push;
  logic [7:0]  ch;
  logic [2:0]  rel;
  logic [31:0] word;
  logic        fifo_full, fifo_empty_nxt;

  assign last_idx    = sel_q ? (LEN_SHORT - 5'd1) : (LEN_LONG - 5'd1);
  assign flushing_wq = (state_q == S_DONE);
  assign snd_busy    = (state_q != S_IDLE);
  assign start_ovr   = ovr_q;

  // Long layout: 0-7 low word, 8 space, 9-16 high word, 17 CR, 18 LF.
  always_comb begin
    word = data_q[31:0];
    rel  = idx_q[2:0];
    if (!sel_q && (idx_q > 5'd8)) begin
      word = data_q[63:32];
      rel  = idx_q[2:0] - 3'd1;
    end
    ch = nib2ascii(word[{~rel, 2'b00} +: 4], UPPER_HEX);
    if (sel_q) begin
      if (idx_q == 5'd8)      ch = CH_CR;
      else if (idx_q == 5'd9) ch = CH_LF;
    end else begin
      if (idx_q == 5'd8)       ch = CH_SP;
      else if (idx_q == 5'd17) ch = CH_CR;
      else if (idx_q == 5'd18) ch = CH_LF;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rdata_snd_start) begin
          data_d  = rdata_snd;
          sel_d   = pc_print_sel;
          idx_d   = '0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        if (!fifo_full) begin
          push  = 1'b1;
          idx_d = idx_q + 5'd1;
          if (idx_q == last_idx) state_d = S_DRAIN;
        end
      end
      // Leave once the final character is being accepted this cycle.
      S_DRAIN: begin
        if (fifo_empty_nxt) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      sel_q   <= 1'b0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_q | (rdata_snd_start & (state_q != S_IDLE));
    end
  end

  uart_char_fifo #(
    .DEPTH_LOG2(QDEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     (ch),
    .ready     (tx_ready),
    .rdata     (tx_data),
    .rvalid    (tx_valid),
    .full      (fifo_full),
    .empty_nxt (fifo_empty_nxt)
  );

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender: lower-case and upper-case instances share stimulus.
module tb_uart_hex_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        tx_ready = 1'b0;
  logic [63:0] rdata = '0;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_flush, b_flush, a_busy, b_busy, a_ovr, b_ovr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int flush_a = 0, flush_b = 0, flush_rel_a = 0, flush_rel_b = 0;
  int hold_viol = 0;
  int base_qa = 0, base_qb = 0, base_fa = 0, base_fb = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = '0;

  logic [63:0] b2b_d [4] = '{64'h00000000_00000000, 64'hFFFFFFFF_FFFFFFFF,
                             64'h13579BDF_2468ACE0, 64'hA5A5A5A5_5A5A5A5A};

  always #5 clk = ~clk;

  uart_hex_sender #(.QDEPTH_LOG2(3), .UPPER_HEX(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .rdata_snd_start(start), .rdata_snd(rdata),
    .pc_print_sel(sel), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(tx_ready),
    .flushing_wq(a_flush), .snd_busy(a_busy), .start_ovr(a_ovr)
  );

  uart_hex_sender #(.QDEPTH_LOG2(3), .UPPER_HEX(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rdata_snd_start(start), .rdata_snd(rdata),
    .pc_print_sel(sel), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(tx_ready),
    .flushing_wq(b_flush), .snd_busy(b_busy), .start_ovr(b_ovr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_valid && tx_ready) q_a.push_back(a_data);
    if (b_valid && tx_ready) q_b.push_back(b_data);
    if (a_flush) begin
      flush_a     <= flush_a + 1;
      flush_rel_a <= cyc - start_cyc;
    end
    if (b_flush) begin
      flush_b     <= flush_b + 1;
      flush_rel_b <= cyc - start_cyc;
    end
    if (rst_n && stall_prev && !(a_valid && a_data == prev_data)) hold_viol <= hold_viol + 1;
    stall_prev <= a_valid && !tx_ready;
    prev_data  <= a_data;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    base_qa = q_a.size();
    base_qb = q_b.size();
    base_fa = flush_a;
    base_fb = flush_b;
  endtask

  task automatic check_stream(input string tag, input bit use_b, input string exp);
    int n;
    n = use_b ? (q_b.size() - base_qb) : (q_a.size() - base_qa);
    check_eq({tag, ".len"}, n, exp.len());
    for (int i = 0; i < exp.len() && i < n; i++) begin
      check_eq($sformatf("%s[%0d]", tag, i),
               use_b ? q_b[base_qb + i] : q_a[base_qa + i], exp.getc(i));
    end
  endtask

  // Called at posedge+1; returns one cycle later with start dropped.
  task automatic send(input logic [63:0] d, input logic s);
    start     = 1'b1;
    rdata     = d;
    sel       = s;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    rdata = ~d;
    sel   = ~s;
  endtask

  task automatic wait_flush(input string tag, input int n, input int budget, input bit use_b);
    int i;
    i = 0;
    while (((use_b ? flush_b - base_fb : flush_a - base_fa) < n) && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    check_eq({tag, ".flush_seen"}, ((use_b ? flush_b - base_fb : flush_a - base_fa) >= n), 1);
  endtask

  initial begin
    int i;
    int f0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.tx_data", a_data, 8'h00);
    check_eq("rst.tx_valid", a_valid, 1'b0);
    check_eq("rst.flush", a_flush, 1'b0);
    check_eq("rst.busy", a_busy, 1'b0);
    check_eq("rst.ovr", a_ovr, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Long record, lower-case, ready tied high
    tx_ready = 1'b1;
    mark();
    send(64'h89ABCDEF_01234567, 1'b0);
    check_eq("long.busy", a_busy, 1'b1);
    wait_flush("long", 1, 60, 1'b0);
    check_stream("long", 1'b0, "01234567 89abcdef\015\012");
    check_eq("long.nflush", flush_a - base_fa, 1);
    check_eq("long.fcyc", flush_rel_a, 21);
    check_eq("long.busy_after", a_busy, 1'b0);

    // Short record, upper-case instance
    mark();
    send(64'hFFFF_FFFF_0000_1F80, 1'b1);
    wait_flush("short", 1, 60, 1'b1);
    check_stream("short", 1'b1, "00001F80\015\012");
    check_eq("short.nflush", flush_b - base_fb, 1);
    check_eq("short.fcyc", flush_rel_b, 12);

    // Backpressure: stalled 40 cycles, then ready toggles
    @(posedge clk); #1;
    tx_ready = 1'b0;
    mark();
    send(64'h89ABCDEF_01234567, 1'b0);
    repeat (39) @(posedge clk);
    @(negedge clk);
    check_eq("bp.idx", dut_a.idx_q, 5'd8);
    check_eq("bp.qcount", dut_a.u_fifo.cnt_q, 4'd8);
    check_eq("bp.valid", a_valid, 1'b1);
    check_eq("bp.head", a_data, 8'h30);
    check_eq("bp.none_sent", q_a.size() - base_qa, 0);
    @(posedge clk); #1;
    i = 0;
    while ((flush_a - base_fa) < 1 && i < 300) begin
      tx_ready = ~tx_ready;
      @(posedge clk); #1;
      i++;
    end
    check_eq("bp.flush_seen", (flush_a - base_fa) >= 1, 1);
    tx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_stream("bp", 1'b0, "01234567 89abcdef\015\012");
    check_eq("bp.nflush", flush_a - base_fa, 1);
    check_eq("bp.ovr", a_ovr, 1'b0);

    // Overrun: second start in cycle 5 of a long record
    mark();
    send(64'h89ABCDEF_01234567, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    rdata = 64'h11112222_33334444;
    sel   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("ovr.set", a_ovr, 1'b1);
    wait_flush("ovr", 1, 60, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_stream("ovr", 1'b0, "01234567 89abcdef\015\012");
    check_eq("ovr.nflush", flush_a - base_fa, 1);
    check_eq("ovr.fcyc", flush_rel_a, 21);
    check_eq("ovr.busy_after", a_busy, 1'b0);

    // Reset mid-record after 7 bytes
    f0 = flush_a;
    mark();
    send(64'h76543210_FEDCBA98, 1'b0);
    i = 0;
    do begin
      @(negedge clk); #1;
      i++;
    end while ((q_a.size() - base_qa) < 7 && i < 40);
    check_eq("rstmid.seven", (q_a.size() - base_qa) >= 7, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid.tx_data", a_data, 8'h00);
    check_eq("rstmid.tx_valid", a_valid, 1'b0);
    check_eq("rstmid.flush", a_flush, 1'b0);
    check_eq("rstmid.busy", a_busy, 1'b0);
    check_eq("rstmid.ovr", a_ovr, 1'b0);
    check_eq("rstmid.busy_b", b_busy, 1'b0);
    check_eq("rstmid.ovr_b", b_ovr, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mark();
    send(64'hDEADBEEF_CAFEF00D, 1'b0);
    wait_flush("rstnew", 1, 60, 1'b0);
    check_stream("rstnew", 1'b0, "cafef00d deadbeef\015\012");
    check_eq("rstnew.fcyc", flush_rel_a, 21);
    check_eq("rstnew.nflush_total", flush_a - f0, 1);

    // Back-to-back: start in the cycle after each flush
    @(posedge clk); #1;
    mark();
    for (int r = 0; r < 4; r++) begin
      send(b2b_d[r], 1'b0);
      i = 0;
      do begin
        @(negedge clk);
        i++;
      end while (!a_flush && i < 60);
      check_eq($sformatf("b2b.flush%0d", r), a_flush, 1'b1);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_stream("b2b", 1'b0, {"00000000 00000000\015\012", "ffffffff ffffffff\015\012",
                               "2468ace0 13579bdf\015\012", "5a5a5a5a a5a5a5a5\015\012"});
    check_eq("b2b.nflush", flush_a - base_fa, 4);
    check_eq("b2b.ovr", a_ovr, 1'b0);

    check_eq("hold_stable", hold_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
